// File: rtl/gate_test_seq.sv
// gate_test_seq
//   Test sequencer for a two-input basic gate. It walks the gate inputs
//   through vectors 0..3, holds each one for a settle period, samples the
//   gate output and compares it against the EXPECT truth table. A pass
//   count and a sticky fail flag are kept for the board LEDs.
//
// Parameters
//   EXPECT          bit i = expected dut_x when {dut_a,dut_b} == i
//   SETTLE_CYCLES   cycles a vector is held before it is sampled (>= 1)
//   DEBOUNCE_CYCLES stable cycles needed to accept a button change (>= 1)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   btn_step  raw pushbutton, asynchronous to clk
//   run       level; while high the vectors sweep automatically
//   dut_a     gate input a (vec[1])
//   dut_b     gate input b (vec[0])
//   dut_x     gate output under test
//   vec       current vector index 0..3
//   pass_cnt  number of matching vectors 0..4
//   fail      sticky mismatch flag
//   busy      high while settling or checking
//   done      high once all four vectors have been checked
module gate_test_seq #(
  parameter logic [3:0] EXPECT          = 4'b1000,
  parameter int         SETTLE_CYCLES   = 2,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       run,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_x,
  output logic [1:0] vec,
  output logic [2:0] pass_cnt,
  output logic       fail,
  output logic       busy,
  output logic       done
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Button path state
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_lvl_q, db_lvl_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          step_q, step_d;

  // Sequencer state
  state_t        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]    vec_q, vec_d;
  logic [2:0]    pass_cnt_q, pass_cnt_d;
  logic          fail_q, fail_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          trig;

  // Stage: synchronize and debounce the pushbutton, emit a press pulse
  always_comb begin
    sync1_d  = btn_step;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
    // Only the press edge produces a pulse; release is silent.
    step_d = db_lvl_d & ~db_lvl_q;
  end

  assign trig = step_q | run;

  // Stage: vector sequencer and result accumulation
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    fail_d       = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end
      end
      S_SETTLE: begin
        // A press arriving here or in CHECK is simply ignored.
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      S_CHECK: begin
        if (dut_x == EXPECT[vec_q]) begin
          pass_cnt_d = pass_cnt_q + 3'd1;
        end else begin
          fail_d = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        // Restart returns to IDLE only; vector 0 needs a fresh trigger.
        if (step_q) begin
          pass_cnt_d = '0;
          fail_d     = 1'b0;
          vec_d      = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_lvl_q     <= 1'b0;
      db_cnt_q     <= '0;
      step_q       <= 1'b0;
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      vec_q        <= '0;
      pass_cnt_q   <= '0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_lvl_q     <= db_lvl_d;
      db_cnt_q     <= db_cnt_d;
      step_q       <= step_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vec      = vec_q;
  assign dut_a    = vec_q[1];
  assign dut_b    = vec_q[0];
  assign pass_cnt = pass_cnt_q;
  assign fail     = fail_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Testbench for gate_test_seq: one sequencer with the default AND table
// around a selectable gate model, and a second one configured for OR
// around an ideal OR gate.
module tb_gate_test_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_step = 1'b0;
  logic       run = 1'b0;
  logic       dut_a, dut_b, dut_x;
  logic [1:0] vec;
  logic [2:0] pass_cnt;
  logic       fail, busy, done;

  logic       or_a, or_b, or_x;
  logic [1:0] or_vec;
  logic [2:0] or_pass;
  logic       or_fail, or_busy, or_done;

  int xmode = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Gate model under test for the main sequencer
  always_comb begin
    dut_x = 1'b0;
    case (xmode)
      0: dut_x = dut_a & dut_b;
      1: dut_x = 1'b1;
      2: dut_x = 1'b0;
      3: dut_x = dut_a | dut_b;
      4: dut_x = dut_a ^ dut_b;
      5: dut_x = ~(dut_a & dut_b);
      default: dut_x = 1'b0;
    endcase
  end

  assign or_x = or_a | or_b;

  gate_test_seq u_dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .run(run),
    .dut_a(dut_a), .dut_b(dut_b), .dut_x(dut_x), .vec(vec),
    .pass_cnt(pass_cnt), .fail(fail), .busy(busy), .done(done)
  );

  gate_test_seq #(.EXPECT(4'b1110)) u_or (
    .clk(clk), .rst(rst), .btn_step(btn_step), .run(run),
    .dut_a(or_a), .dut_b(or_b), .dut_x(or_x), .vec(or_vec),
    .pass_cnt(or_pass), .fail(or_fail), .busy(or_busy), .done(or_done)
  );

  typedef struct {
    int xmode;
    int exp_pass;
    int exp_fail;
  } sweep_vec_t;

  sweep_vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press();
    btn_step = 1'b1;
    tick(25);
    btn_step = 1'b0;
    tick(25);
  endtask

  initial begin
    int ev;
    bit saw_busy;

    tbl[0] = '{xmode: 0, exp_pass: 4, exp_fail: 0};
    tbl[1] = '{xmode: 1, exp_pass: 1, exp_fail: 1};
    tbl[2] = '{xmode: 2, exp_pass: 3, exp_fail: 1};
    tbl[3] = '{xmode: 3, exp_pass: 2, exp_fail: 1};
    tbl[4] = '{xmode: 4, exp_pass: 1, exp_fail: 1};
    tbl[5] = '{xmode: 5, exp_pass: 0, exp_fail: 1};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_vec", vec, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ab", {dut_a, dut_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Auto sweep with an ideal AND; OR instance sweeps alongside
    xmode = 0;
    run = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      ev = (i / 4 > 3) ? 3 : i / 4;
      chk($sformatf("auto_vec_%0d", i), vec, ev);
      chk($sformatf("auto_ab_%0d", i), {dut_a, dut_b}, ev);
      chk($sformatf("auto_pass_%0d", i), pass_cnt, i / 4);
      chk($sformatf("auto_busy_%0d", i), busy, (i % 4 != 0) ? 1 : 0);
      chk($sformatf("auto_done_%0d", i), done, (i == 16) ? 1 : 0);
    end
    chk("auto_fail", fail, 0);
    chk("or_done", or_done, 1);
    chk("or_pass", or_pass, 4);
    chk("or_fail", or_fail, 0);
    tick(6);
    chk("run_norestart_done", done, 1);
    chk("run_norestart_vec", vec, 3);
    chk("run_norestart_pass", pass_cnt, 4);

    // Table of gate models swept automatically
    for (int r = 0; r < 6; r++) begin
      run = 1'b0;
      xmode = tbl[r].xmode;
      do_reset();
      run = 1'b1;
      tick(16);
      chk($sformatf("tbl%0d_done", r), done, 1);
      chk($sformatf("tbl%0d_pass", r), pass_cnt, tbl[r].exp_pass);
      chk($sformatf("tbl%0d_fail", r), fail, tbl[r].exp_fail);
    end

    // Manual stepping with the pushbutton
    run = 1'b0;
    xmode = 0;
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      press();
      chk($sformatf("man%0d_vec", p), vec, (p < 4) ? p : 3);
      chk($sformatf("man%0d_pass", p), pass_cnt, p);
      chk($sformatf("man%0d_done", p), done, (p == 4) ? 1 : 0);
    end
    press();
    chk("man5_vec", vec, 0);
    chk("man5_pass", pass_cnt, 0);
    chk("man5_done", done, 0);
    chk("man5_busy", busy, 0);
    press();
    chk("man6_vec", vec, 1);
    chk("man6_pass", pass_cnt, 1);

    // Short press is rejected
    do_reset();
    saw_busy = 1'b0;
    btn_step = 1'b1;
    tick(10);
    btn_step = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch_busy", saw_busy, 0);
    chk("glitch_vec", vec, 0);

    // Bouncing press yields exactly one advance
    for (int i = 0; i < 8; i++) begin
      btn_step = (i % 2 == 0);
      tick(1);
    end
    btn_step = 1'b1;
    tick(30);
    btn_step = 1'b0;
    tick(30);
    chk("bounce_vec", vec, 1);
    chk("bounce_pass", pass_cnt, 1);
    chk("bounce_busy", busy, 0);

    // Press lands while vector 0 is settling and is dropped
    do_reset();
    btn_step = 1'b1;
    tick(17);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(30);
    btn_step = 1'b0;
    tick(30);
    chk("busy_press_vec", vec, 1);
    chk("busy_press_busy", busy, 0);
    chk("busy_press_done", done, 0);
    chk("busy_press_pass", pass_cnt, 1);

    // Asynchronous reset during CHECK of vector 2
    xmode = 1;
    do_reset();
    run = 1'b1;
    tick(11);
    chk("mid_pre_vec", vec, 2);
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_fail", fail, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_vec", vec, 0);
    chk("mid_ab", {dut_a, dut_b}, 0);
    chk("mid_pass", pass_cnt, 0);
    chk("mid_fail", fail, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    xmode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);
    chk("restart_vec", vec, 1);
    chk("restart_pass", pass_cnt, 1);
    tick(12);
    chk("restart_done", done, 1);
    chk("restart_pass4", pass_cnt, 4);
    chk("restart_fail", fail, 0);
    run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_test_seq.md
# gate_test_seq

Test sequencer for the two-input basic-gate labs. It drives the input pins of a 2-input gate under test (DUT), steps through all four input vectors, samples the gate output after a settle delay, and checks it against a parameterised truth table. It accumulates a pass count and a sticky fail flag for the board LEDs. It sits directly around the gate: its `dut_a`/`dut_b` feed the gate inputs and its `dut_x` consumes the gate output.

## Interface
- `EXPECT`, default 4'b1000: expected gate output per vector. Bit i is the expected `dut_x` when `{dut_a,dut_b}` = i. The default is the AND truth table.
- `SETTLE_CYCLES`, default 2: cycles vectors are held before sampling. Must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a button level change. Must be ≥ 1.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_step` in 1: raw pushbutton, asynchronous to `clk`.
- `run` in 1: level input. While high, vectors sweep automatically.
- `dut_a` out 1: gate input a. Equals `vec[1]`.
- `dut_b` out 1: gate input b. Equals `vec[0]`.
- `dut_x` in 1: gate output under test.
- `vec` out 2: current vector index, 0..3.
- `pass_cnt` out 3: number of vectors that matched, 0..4.
- `fail` out 1: sticky mismatch flag.
- `busy` out 1: high in SETTLE or CHECK.
- `done` out 1: high in DONE.

## Operation
- **Reset values:** state=IDLE, `vec`=0, `dut_a`=`dut_b`=0, `pass_cnt`=0, `fail`=0, `busy`=0, `done`=0. Synchronizer flops, debounced level and counters are all 0.
- **Reset mid-operation:** aborts immediately to the reset values. No partial result is retained.
- **Button path:**
  - 2-flop synchronizer on `btn_step`.
  - The debounce counter increments while the synchronized level differs from the debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the levels still differ, the debounced level takes the new value and the counter clears.
  - `step` is a one-cycle pulse on a 0→1 transition of the debounced level only. Release produces no pulse.
- **Trigger:** `trig` = `step` OR `run`.
- **State IDLE:** `dut_a`/`dut_b` present `vec`. If `trig`, go to SETTLE and clear the settle counter.
- **State SETTLE:** hold vectors. When the counter = SETTLE_CYCLES−1, go to CHECK; otherwise increment the counter.
- **State CHECK:** sample `dut_x` and compare to `EXPECT[vec]`.
  - Match: `pass_cnt` += 1.
  - Mismatch: `fail` ← 1.
  - If `vec`=3, go to DONE and keep `vec`=3. Otherwise `vec` += 1 and go to IDLE.
- **State DONE:** results frozen.
  - `run` alone never restarts.
  - A `step` pulse clears `pass_cnt`, `fail` and `vec` to 0 and goes to IDLE. That pulse does not also launch vector 0.
- **Step while busy:** `step` pulses in SETTLE or CHECK are dropped, not queued.
- **Simultaneous events:** `step` and `run` together in IDLE count as a single trigger.
- **Widths:** `pass_cnt` never exceeds 4. There is no `vec` wrap-around inside a sweep; the only return to 0 is the DONE restart or reset.

## Timing
- **Per vector:** IDLE 1 cycle + SETTLE SETTLE_CYCLES cycles + CHECK 1 cycle = SETTLE_CYCLES+2 cycles with `run` held high.
- **Full sweep:** with `run` high from the first IDLE cycle, `done` rises 4·(SETTLE_CYCLES+2) cycles later, i.e. 16 cycles at the defaults.
- **Vector hold:** `dut_a`/`dut_b` change only on the CHECK→IDLE edge, so each vector is stable for at least SETTLE_CYCLES+1 cycles before its sample.
- **Result updates:** `pass_cnt` and `fail` update on the edge leaving CHECK and are visible in the following cycle.
- **Button latency:** the `step` pulse occurs DEBOUNCE_CYCLES+2 cycles (±1 for input phase) after `btn_step` goes and stays high.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- **Manual mode (`run`=0):** one `step` pulse advances exactly one vector.

## Test plan
- **Auto sweep, correct gate.** Reset, attach an ideal AND, `run`=1. Expected: `vec` steps 0,1,2,3 every 4 cycles; `done`=1 at cycle 16; `pass_cnt`=4; `fail`=0; `dut_a`/`dut_b` visit 00,01,10,11.
- **Faulty gate.** `dut_x` tied to 1, `run`=1. Expected: `pass_cnt`=1, `fail`=1, `done`=1. Separately with EXPECT=4'b1110 and an ideal OR: `pass_cnt`=4, `fail`=0.
- **Manual stepping.** `run`=0, four clean presses ≥ 20 cycles each. Expected: one vector per press; `done` after the 4th.
  - A fifth press returns to IDLE with `pass_cnt`=0 and `vec`=0.
  - A sixth press starts vector 0.
- **Debounce.** Drive `btn_step` high for 10 cycles, then low. Expected: no `step` and no state change.
  - A bouncing press (1/0 toggles for 8 cycles, then high for 30) gives exactly one advance.
- **Press while busy.** Trigger vector 0, then inject a `step` pulse during SETTLE. Expected: dropped; `vec`=1 and state IDLE afterwards.
- **Reset mid-sweep.** Assert `rst` asynchronously in CHECK of vector 2. Expected: outputs go to reset values immediately, without waiting for a clock edge; the sweep restarts from `vec`=0 after release.
